// File: rtl/uart_core.sv
// 8N1 UART transmitter/receiver with a seven-segment view of the last received nibble.
// Optional feature macro: UART_DISPLAY_EN (builds the hex-to-segment decoder for display_out).
module uart_core #(
    parameter int CLOCKS_PER_PULSE = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] data_in,
    input  logic       data_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [7:0] led_out,
    output logic [7:0] display_out
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]    tx_bit_r;
    logic [7:0]    tx_shift_r;

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic [1:0]    rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic          byte_done_s;

    // Transmit FSM: the byte is captured when the frame starts, then shifted out LSB first.
    always_ff @(posedge clk) begin
        if (rstn) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    tx_cnt_r <= CNT_ZERO;
                    tx_bit_r <= 3'd0;
                    if (data_en) begin
                        tx_state_r <= ST_START;
                        tx_shift_r <= {4'b0000, data_in};
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                    end else begin
                        tx         <= 1'b1;
                        tx_busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_bit_r   <= 3'd0;
                        tx         <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_state_r <= ST_DATA;
                    end else begin
                        tx_cnt_r   <= tx_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= ST_STOP;
                            tx         <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx         <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_state_r <= ST_IDLE;
                        tx_busy    <= 1'b0;
                    end else begin
                        tx_cnt_r   <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_cnt_r   <= CNT_ZERO;
                    tx         <= 1'b1;
                    tx_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous serial input, idling high.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM: half-bit start validation, then one sample per bit period at mid-bit.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                ST_IDLE: begin
                    rx_cnt_r <= CNT_ZERO;
                    rx_bit_r <= 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_r <= ST_START;
                    end else begin
                        rx_state_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_r   <= rx_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_bit_r   <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= ST_IDLE;
                    end else begin
                        rx_cnt_r   <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    rx_state_r <= ST_IDLE;
                    rx_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // A byte completes only on a stop sample that reads high; a low stop bit is a framing error.
    always_comb begin
        byte_done_s = 1'b0;
        if ((rx_state_r == ST_STOP) && (rx_cnt_r == BIT_LAST) && rx_sync_r) begin
            byte_done_s = 1'b1;
        end else begin
            byte_done_s = 1'b0;
        end
    end

    // Received-byte register and ready flag; a completing byte wins over ready_clr.
    always_ff @(posedge clk) begin
        if (rstn) begin
            ready   <= 1'b0;
            led_out <= 8'h00;
        end else if (byte_done_s) begin
            ready   <= 1'b1;
            led_out <= rx_shift_r;
        end else if (ready_clr) begin
            ready   <= 1'b0;
        end
    end

`ifdef UART_DISPLAY_EN
    function automatic logic [7:0] seg7_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            4'hF:    code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    assign display_out = seg7_code(led_out[3:0]);
`else
    // Display blanked (active-low segments all off) when the decoder is not built.
    assign display_out = 8'hFF;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core at CLOCKS_PER_PULSE=4, with optional tx->rx loopback.
module tb_uart_core;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] data_in;
    logic       data_en;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic       ready;
    logic       ready_clr;
    logic [7:0] led_out;
    logic [7:0] display_out;

    logic       loop_en;
    logic       rx_drv;
    int         passed = 0;
    int         total  = 0;

    assign rx = loop_en ? tx : rx_drv;

    uart_core #(.CLOCKS_PER_PULSE(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data_in     (data_in),
        .data_en     (data_en),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .rx          (rx),
        .ready       (ready),
        .ready_clr   (ready_clr),
        .led_out     (led_out),
        .display_out (display_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_disp(input logic [3:0] nib);
`ifdef UART_DISPLAY_EN
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;  4'h1: code = 8'hF9;  4'h2: code = 8'hA4;  4'h3: code = 8'hB0;
            4'h4: code = 8'h99;  4'h5: code = 8'h92;  4'h6: code = 8'h82;  4'h7: code = 8'hF8;
            4'h8: code = 8'h80;  4'h9: code = 8'h90;  4'hA: code = 8'h88;  4'hB: code = 8'h83;
            4'hC: code = 8'hC6;  4'hD: code = 8'hA1;  4'hE: code = 8'h86;  default: code = 8'h8E;
        endcase
        return code;
`else
        return (nib == 4'h0) ? 8'hFF : 8'hFF;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic wait_ready(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Drive one serial frame on rx (start, 8 data LSB first, given stop level), then idle high.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (4) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        bit         got;
        bit         saw;
        logic [9:0] frame5;
        logic       exp_tx;
        logic       exp_busy;

        rstn = 1'b1; data_in = 4'h0; data_en = 1'b0; ready_clr = 1'b0;
        loop_en = 1'b1; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", {7'd0, tx}, 8'h01);
        check("rst_busy", {7'd0, tx_busy}, 8'h00);
        check("rst_ready", {7'd0, ready}, 8'h00);
        check("rst_led", led_out, 8'h00);
        check("rst_disp", display_out, exp_disp(4'h0));
        rstn = 1'b0;
        @(negedge clk);

        // Frame timing for data_in=5, data_in changed after latch; loopback receives it with ready_clr=0.
        frame5 = 10'b1_0000_0101_0;
        data_in = 4'h5; data_en = 1'b1;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            if (k == 0) begin
                data_en = 1'b0;
                data_in = 4'hA;
            end
            exp_tx   = (k < 40) ? frame5[k / 4] : 1'b1;
            exp_busy = (k < 40) ? 1'b1 : 1'b0;
            check($sformatf("tx_bit_k%0d", k), {7'd0, tx}, {7'd0, exp_tx});
            check($sformatf("busy_k%0d", k), {7'd0, tx_busy}, {7'd0, exp_busy});
        end
        check("rx5_ready", {7'd0, ready}, 8'h01);
        check("rx5_led", led_out, 8'h05);
        check("rx5_disp", display_out, exp_disp(4'h5));
        repeat (5) @(negedge clk);
        check("ready_hold", {7'd0, ready}, 8'h01);
        ready_clr = 1'b1;
        @(negedge clk);
        check("ready_cleared", {7'd0, ready}, 8'h00);

        // data_en held high with ready_clr tied high: ready is a single-cycle pulse.
        data_in = 4'h1; data_en = 1'b1;
        wait_ready(100, got);
        check("pulse_seen", {7'd0, got}, 8'h01);
        check("pulse_led", led_out, 8'h01);
        check("pulse_disp", display_out, exp_disp(4'h1));
        @(negedge clk);
        check("pulse_len", {7'd0, ready}, 8'h00);
        data_en = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) begin
                saw = 1'b1;
                break;
            end
        end
        check("busy_drop", {7'd0, saw}, 8'h01);
        repeat (4) @(negedge clk);

        // Loopback sweep with a reset pulse and a data_en toggle per byte.
        for (int v = 1; v < 16; v++) begin
            rstn = 1'b1;
            @(negedge clk);
            rstn = 1'b0;
            check($sformatf("sweep_rst_led_%0d", v), led_out, 8'h00);
            data_in = 4'(v); data_en = 1'b1;
            @(negedge clk);
            data_en = 1'b0;
            wait_ready(100, got);
            check($sformatf("sweep_got_%0d", v), {7'd0, got}, 8'h01);
            check($sformatf("sweep_led_%0d", v), led_out, {4'h0, 4'(v)});
            repeat (3) @(negedge clk);
        end
        check("sweep_disp_F", display_out, exp_disp(4'hF));

        // Directly driven rx: a full byte, a 1-clock glitch, then a frame with a low stop bit.
        loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        send_rx(8'hA7, 1'b1);
        wait_ready(10, got);
        check("rxA7_got", {7'd0, got}, 8'h01);
        check("rxA7_led", led_out, 8'hA7);
        check("rxA7_disp", display_out, exp_disp(4'h7));
        repeat (3) @(negedge clk);

        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready === 1'b1) saw = 1'b1;
        end
        check("glitch_noready", {7'd0, saw}, 8'h00);
        check("glitch_led", led_out, 8'hA7);

        saw = 1'b0;
        fork
            send_rx(8'h3C, 1'b0);
            for (int i = 0; i < 52; i++) begin
                @(negedge clk);
                if (ready === 1'b1) saw = 1'b1;
            end
        join
        check("frame_err_noready", {7'd0, saw}, 8'h00);
        check("frame_err_led", led_out, 8'hA7);

        // Leave ready set, then reset in the middle of a transmit frame.
        ready_clr = 1'b0;
        send_rx(8'h5A, 1'b1);
        wait_ready(10, got);
        check("rx5A_got", {7'd0, got}, 8'h01);
        check("rx5A_led", led_out, 8'h5A);
        loop_en = 1'b1;
        data_in = 4'h3; data_en = 1'b1;
        @(negedge clk);
        data_en = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_busy", {7'd0, tx_busy}, 8'h01);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_tx", {7'd0, tx}, 8'h01);
        check("midrst_busy", {7'd0, tx_busy}, 8'h00);
        check("midrst_ready", {7'd0, ready}, 8'h00);
        check("midrst_led", led_out, 8'h00);
        check("midrst_disp", display_out, exp_disp(4'h0));
        rstn = 1'b0;
        repeat (60) @(negedge clk);
        check("after_tx", {7'd0, tx}, 8'h01);
        check("after_busy", {7'd0, tx_busy}, 8'h00);
        check("after_ready", {7'd0, ready}, 8'h00);
        check("after_led", led_out, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
